// File: rtl/bin2bcd_if.sv
// ---------------------------------------------------------------------------
// bin2bcd_if : handshake and result bundle for bin2bcd_seq.
//
// Signals
//   start    master -> slave  request a conversion of bin (taken only when idle)
//   bin      master -> slave  unsigned value, BIN_W bits
//   busy     slave  -> master conversion in progress
//   done     slave  -> master one-cycle pulse, bcd/overflow just updated
//   bcd      slave  -> master 4*DIGITS bits, nibble i = decimal digit i
//   overflow slave  -> master value did not fit in DIGITS digits
//   blank    slave  -> master leading-zero mask (only with BIN2BCD_BLANK_EN)
//
// Handshake: start is a level request sampled on every rising clock edge
// while busy=0; the edge that samples start=1 captures bin and raises busy.
// There is no backpressure on the result side: done is a single-cycle pulse
// and bcd/overflow stay stable until the next done.
// ---------------------------------------------------------------------------
interface bin2bcd_if #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;
`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0]     blank;

  modport master (output start, bin, input busy, done, bcd, overflow, blank);
  modport slave  (input start, bin, output busy, done, bcd, overflow, blank);
`else
  modport master (output start, bin, input busy, done, bcd, overflow);
  modport slave  (input start, bin, output busy, done, bcd, overflow);
`endif
endinterface

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq : sequential binary-to-BCD converter (shift-add-3, one input
// bit per clock, fixed latency).
//
// Parameters
//   BIN_W  width of the binary input (>=1)
//   DIGITS number of BCD digits produced (>=1), digit 0 = units
//
// Ports
//   clock        rising-edge system clock
//   reset        asynchronous active-high reset
//   bus          bin2bcd_if slave modport (start/bin in, busy/done/bcd/overflow out)
//   o_dbg_state  current FSM state (IDLE=0, SHIFT=1, FINISH=2)
//
// Optional feature: define BIN2BCD_BLANK_EN to add the leading-zero blank
// mask (bus.blank). Without it the mask register and logic do not exist.
//
// Timing: start accepted at edge T, SHIFT on edges T+1..T+BIN_W, FINISH
// registers the result at edge T+BIN_W+1, so done is high in the cycle
// after that edge and the next start can be taken on edge T+BIN_W+2.
// ---------------------------------------------------------------------------
module bin2bcd_seq #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic       clock,
  input  logic       reset,
  bin2bcd_if.slave   bus,
  output logic [1:0] o_dbg_state
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  logic [1:0]          r_state;
  logic [BIN_W-1:0]    r_shift;
  logic [4*DIGITS-1:0] r_scratch;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_ovf_acc;
  logic [4*DIGITS-1:0] r_bcd;
  logic                r_ovf;
  logic                r_done;

  logic [4*DIGITS-1:0] w_adj;
  logic [4*DIGITS-1:0] w_next_scratch;
  logic                w_ovf_out;

  // Add-3 correction: every digit >=5 gets +3 before the shift so it
  // carries into the next digit after doubling. Purely per-column.
  always_comb begin
    w_adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_scratch[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
      end else begin
        w_adj[4*i +: 4] = r_scratch[4*i +: 4];
      end
    end
  end

  // Shift {scratch, shift} left by one; the bit leaving the top digit is
  // lost from the result and only recorded as overflow.
  assign w_next_scratch = (w_adj << 1) | {{(4*DIGITS-1){1'b0}}, r_shift[BIN_W-1]};
  assign w_ovf_out      = w_adj[4*DIGITS-1];

`ifdef BIN2BCD_BLANK_EN
  localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

  logic [DIGITS-1:0] r_blank;
  logic [DIGITS-1:0] w_blank;
  logic              w_zero_above;

  // Digit i is blank when it and every digit above it is zero; the units
  // digit is never blanked so a zero value still shows "0".
  always_comb begin
    w_blank      = '0;
    w_zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_zero_above = w_zero_above & (r_scratch[4*i +: 4] == 4'd0);
      w_blank[i]   = w_zero_above;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_blank <= BLANK_RST;
    end else if (r_state == S_FINISH) begin
      r_blank <= w_blank;
    end
  end

  assign bus.blank = r_blank;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_ovf_acc <= 1'b0;
      r_bcd     <= '0;
      r_ovf     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_shift   <= bus.bin;
            r_scratch <= '0;
            r_ovf_acc <= 1'b0;
            r_cnt     <= CNT_W'(BIN_W);
            r_state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_scratch <= w_next_scratch;
          r_shift   <= r_shift << 1;
          r_ovf_acc <= r_ovf_acc | w_ovf_out;
          r_cnt     <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= S_FINISH;
          end
        end
        S_FINISH: begin
          r_bcd   <= r_scratch;
          r_ovf   <= r_ovf_acc;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = r_done;
  assign bus.bcd      = r_bcd;
  assign bus.overflow = r_ovf;
  assign o_dbg_state  = r_state;

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Parametrised sequential binary-to-BCD converter for score and counter display paths; feeds the seven-segment digit drivers.
- Generalises the fixed 8-bit, 3-digit converter to any input width and digit count.
- Adds a start/busy/done handshake, an overflow flag, and an optional leading-zero blank mask.
- Uses shift-add-3 (double dabble): exactly one input bit per clock, so latency is fixed.

Parameters:
- BIN_W, 16, width of binary input (>=1).
- DIGITS, 5, number of BCD digits produced (>=1); digit 0 = units.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request conversion of bin; sampled only in IDLE.
- bin  input  BIN_W  unsigned value to convert; captured on the accepting edge only.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd/overflow update.
- bcd  output  4*DIGITS  result; nibble i = digit i (bcd[3:0] = units).
- overflow  output  1  result exceeded 10^DIGITS-1; bcd holds value mod 10^DIGITS.

Behaviour:
- Reset (async, active-high), asynchronous to clock:
  - state=IDLE; busy=0; done=0; bcd=0; overflow=0.
  - Internal shift register, scratch BCD and bit counter cleared.
- Reset mid-conversion aborts with no done pulse and no output update.
- States: IDLE, SHIFT, FINISH.
- IDLE:
  - busy=0.
  - On an edge with start=1: capture bin into shift register, clear scratch digits and overflow accumulator, load counter=BIN_W, go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT, one bit per edge, busy=1:
  - Step 1: each scratch digit >=5 gets +3 (all digits in parallel, 4-bit add).
  - Step 2: shift {scratch, shift register} left one bit; the input MSB enters digit 0 bit 0.
  - The bit shifted out of the top digit ORs into the overflow accumulator.
  - Counter decrements; when the counter reaches 1 on this edge, go to FINISH.
- FINISH, one cycle, busy=1:
  - bcd <= scratch; overflow <= accumulator; done=1 for exactly this cycle; go to IDLE.
- Latency: start accepted at edge T; SHIFT on edges T+1..T+BIN_W; done high in the cycle after edge T+BIN_W+1.
  - This gives a BIN_W+2-edge turnaround between back-to-back starts.
- start while busy=1 is ignored, with no queuing. Holding start high re-triggers on the first IDLE edge after done.
- bin changes after the accepting edge have no effect on the conversion in progress.
- bcd and overflow hold their last values between done pulses. They never show partial results.
- Overflow: digits above DIGITS are dropped. Low digits stay exact because the correction logic in each column never propagates downward.
- No overflow is possible when 10^DIGITS > 2^BIN_W-1. The flag then stays 0.
- BIN_W=1 is valid: one SHIFT cycle.

Optional Feature:
- Macro: BIN2BCD_BLANK_EN.
- When defined:
  - Extra output port blank [DIGITS-1:0].
  - blank[i]=1 iff digit i and all higher digits are zero. blank[0] is always 0.
  - blank is registered with bcd on the done cycle; reset value is all-ones except bit 0.
  - Overflow does not affect the mask.
- When undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset pulse mid-conversion (BIN_W=16): assert reset 5 cycles after start with bin=1234.
  - Outputs go 0 immediately, asynchronously, with no done.
  - Next start with bin=1234 gives bcd=0x01234.
- bin=255, BIN_W=16, DIGITS=5: start at edge T.
  - busy=1 for T+1..T+17; done pulses once after edge T+17.
  - bcd=0x00255, overflow=0.
- bin=65535, DIGITS=5: bcd=0x65535, overflow=0.
- Same value with DIGITS=4: bcd=0x5535, overflow=1.
- Start asserted every cycle with bin toggling 9/10:
  - Conversions are accepted only in IDLE, every 18 edges.
  - Each result matches the bin captured at its own accept edge (0x00009 / 0x00010).
- Exhaustive sweep BIN_W=8, DIGITS=3, bin 0..255:
  - bcd equals the decimal value for every input; overflow=0; done count=256.
- With BIN2BCD_BLANK_EN, DIGITS=5:
  - bin=0 -> blank=5'b11110.
  - bin=305 -> blank=5'b11000.
  - bin=40000 -> blank=5'b00000.
